// File: rtl/frame_ram_arbiter.sv
// Round-robin arbiter for the frame RAM read port: recognition engine (port 0)
// and dump streamer (port 1). Grants are combinational; read data returns 1 cycle later.
module frame_ram_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              Clk,
  input  logic              i_Rst,
  input  logic              i_Load_Active,
  input  logic              i_Req0,
  input  logic [ADDR_W-1:0] i_Addr0,
  output logic              o_Gnt0,
  output logic              o_Valid0,
  output logic [DATA_W-1:0] o_Data0,
  input  logic              i_Req1,
  input  logic [ADDR_W-1:0] i_Addr1,
  output logic              o_Gnt1,
  output logic              o_Valid1,
  output logic [DATA_W-1:0] o_Data1,
  output logic [ADDR_W-1:0] o_Ram_Addr,
  output logic              o_Ram_Rd_En,
  input  logic [DATA_W-1:0] i_Ram_Data,
  output logic [1:0]        o_Owner,
  output logic              o_Busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_t;

  owner_t            owner_reg, owner_next;
  logic              last_winner_reg, last_winner_next;
  logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic [1:0]        valid_reg;
  logic              sel_reg;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0]        valid_out;
  logic              cur_port;
  logic              keep_owner;
  logic              new_port;

  assign req = {i_Req1, i_Req0};

  // The owner may continue while under its burst budget, or indefinitely if
  // the other port is idle.
  assign cur_port   = (owner_reg == OWN_P1);
  assign keep_owner = (owner_reg != OWN_NONE) && req[cur_port] &&
                      ((burst_cnt_reg < MAX_CNT) || !req[!cur_port]);

  always_comb begin
    gnt              = 2'b00;
    owner_next       = OWN_NONE;
    last_winner_next = last_winner_reg;
    burst_cnt_next   = '0;
    new_port         = 1'b0;
    if (i_Rst || i_Load_Active) begin
      gnt = 2'b00;
    end else if (keep_owner) begin
      gnt[cur_port]  = 1'b1;
      owner_next     = owner_reg;
      burst_cnt_next = (burst_cnt_reg == MAX_CNT) ? MAX_CNT : burst_cnt_reg + 1'b1;
    end else if (|req) begin
      // A tie goes to the port that did not win last; otherwise the lone requester.
      new_port         = (&req) ? !last_winner_reg : req[1];
      gnt[new_port]    = 1'b1;
      owner_next       = new_port ? OWN_P1 : OWN_P0;
      last_winner_next = new_port;
      burst_cnt_next   = CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      owner_reg       <= OWN_NONE;
      last_winner_reg <= 1'b1;
      burst_cnt_reg   <= '0;
      valid_reg       <= 2'b00;
      sel_reg         <= 1'b0;
    end else begin
      owner_reg       <= owner_next;
      last_winner_reg <= last_winner_next;
      burst_cnt_reg   <= burst_cnt_next;
      valid_reg       <= gnt;
      if (|gnt) begin
        sel_reg <= gnt[1];
      end
    end
  end

  // A read in flight when reset arrives is dropped rather than reported.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_valid
      assign valid_out[gi] = valid_reg[gi] & ~i_Rst;
    end
  endgenerate

  assign o_Gnt0      = gnt[0];
  assign o_Gnt1      = gnt[1];
  assign o_Valid0    = valid_out[0];
  assign o_Valid1    = valid_out[1];
  assign o_Data0     = i_Ram_Data;
  assign o_Data1     = i_Ram_Data;
  assign o_Ram_Rd_En = |gnt;
  assign o_Ram_Addr  = (gnt[1] || (!gnt[0] && sel_reg)) ? i_Addr1 : i_Addr0;
  assign o_Owner     = owner_next;
  assign o_Busy      = o_Ram_Rd_En | valid_out[0] | valid_out[1];

endmodule

// File: doc/frame_ram_arbiter.md
# frame_ram_arbiter

Shares the single read port of the frame RAM between two requesters: the color-recognition engine (port 0) and a raw-frame dump streamer (port 1). It blocks all reads while the camera capture path is writing a frame. It sits between the top-level capture FSM and the RAM's read-address/data pins. Ownership is round-robin with a bounded burst length, so neither requester starves the other.

## Interface
Parameters:
- ADDR_W, 15, frame RAM address width
- DATA_W, 8, frame RAM data width
- MAX_BURST, 16, maximum consecutive grants to one owner while the other requester waits (≥1)

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Load_Active  in  1  camera is writing RAM; suppresses all read grants
- i_Req0  in  1  port 0 (recognition) read request, held with address
- i_Addr0  in  ADDR_W  port 0 read address
- o_Gnt0  out  1  port 0 access accepted this cycle
- o_Valid0  out  1  o_Data0 holds data for the port 0 access granted last cycle
- o_Data0  out  DATA_W  read data to port 0
- i_Req1, i_Addr1, o_Gnt1, o_Valid1, o_Data1: same as port 0, for port 1 (dump)
- o_Ram_Addr  out  ADDR_W  RAM read address
- o_Ram_Rd_En  out  1  RAM read enable
- i_Ram_Data  in  DATA_W  RAM read data, registered in RAM, 1-cycle latency
- o_Owner  out  2  current owner: 2'b00 none, 2'b01 port 0, 2'b10 port 1
- o_Busy  out  1  high in any cycle with o_Ram_Rd_En or o_Valid0/o_Valid1 high

## Operation
- Registered state:
  - owner: none/0/1
  - last_winner: 0/1
  - burst_cnt: width clog2(MAX_BURST+1), saturating at MAX_BURST
  - valid0_q, valid1_q
- Grant decision is combinational from the registered state and the current requests. At most one grant per cycle.
- Decision, in priority order:
  - **Lock.** i_Rst or i_Load_Active high → no grant. Next cycle: owner=none, burst_cnt=0.
  - **Keep owner.** Owner valid and its request high, and (burst_cnt<MAX_BURST or the other request low) → grant owner. burst_cnt+1, saturating.
  - **Tie.** Both requests high → grant the port ≠ last_winner.
  - **Single request.** Exactly one request high → grant that port.
  - **No request.** No grant. Next cycle: owner=none, burst_cnt=0.
- On a new owner: owner←winner, last_winner←winner, burst_cnt←1.
- Owner handoff when the owner drops its request or hits MAX_BURST with the other port waiting costs 0 cycles: the other port is granted in that same cycle.
- RAM address mux:
  - o_Ram_Addr = granted port's address.
  - With no grant, o_Ram_Addr holds its last value (registered mux select).
  - o_Ram_Rd_En = o_Gnt0 | o_Gnt1.
- Return path:
  - valid0_q ← o_Gnt0; valid1_q ← o_Gnt1.
  - o_ValidN = validN_q.
  - o_Data0 = o_Data1 = i_Ram_Data (combinational passthrough). Requesters qualify with their own valid.
- Requester contract: hold req and address stable until the grant is seen. A requester may change its address every granted cycle to stream.

## Timing
- Reset values: o_Gnt0/1=0, o_Valid0/1=0, o_Ram_Rd_En=0, o_Owner=00, o_Busy=0, burst_cnt=0, last_winner=1 (port 0 wins the first tie).
- Reset asserted mid-burst:
  - Grants drop in the same cycle.
  - Valids clear on the next edge. Data from the read issued the cycle before reset is discarded; no o_Valid is produced for it.
- Latency:
  - Grant comes in the same cycle as the request when the port is eligible.
  - Data/valid arrive 1 cycle after the grant.
  - Sustained throughput: 1 access/cycle.
- i_Load_Active rising:
  - Grants stop in that cycle.
  - A read granted in the previous cycle still returns its o_Valid the following cycle.
- i_Load_Active falling: arbitration resumes in that cycle, from owner=none.
- Fairness: while both ports request continuously, the grant pattern is MAX_BURST to one port, then MAX_BURST to the other. Maximum wait for a requesting port is MAX_BURST cycles (lock excluded).
- Address width: addresses pass through unmodified. No wrap or bounds check; requesters keep addresses < frame size.

## Test plan
- **Reset, first tie.** Reset, then i_Req0=i_Req1=1 in the same cycle → o_Gnt0=1 in that cycle; o_Valid0=1 next cycle with o_Data0 = RAM[i_Addr0].
- **Burst limit.** MAX_BURST=4; both ports request continuously → grants 0,0,0,0,1,1,1,1,0… The burst sequence is fixed; the first port served is the one ≠ last_winner. o_Owner tracks each change with no idle cycle between handoffs.
- **Single requester streaming.** Only i_Req1 high, addresses 0..19 → 20 consecutive grants (no MAX_BURST cut); valid data returned for addresses 0..19 in order, each 1 cycle after its grant.
- **Load lock mid-stream.** Port 0 streaming; assert i_Load_Active at cycle N → o_Gnt0=0 from cycle N; o_Valid0=1 at N (for the grant at N-1) and 0 at N+1. Deassert → grant resumes in the same cycle.
- **Reset mid-burst.** i_Rst during an active burst → grants 0 in that cycle; all outputs at reset values the next cycle; after release, both ports requesting → port 0 granted first.
- **Early handoff.** Owner port 0 drops its request at burst_cnt=2 while port 1 is waiting → o_Gnt1=1 in that same cycle, o_Owner=10.
